dff_bank_ctrl: RTL

Write controller for a bank of DFF-based registers shared by four requesters. Arbitrates requesters round-robin and commits one write per clock into a DEPTH x WIDTH register bank. Also runs a hardware clear sweep that zeroes the bank one entry per cycle. Sits between the lab's DFF storage primitives and the requesting units, and is the only writer of the bank.

---
 rtl/dff_bank_pkg.sv | 12 +
 rtl/dff_bank_ctrl_if.sv | 45 ++++
 rtl/rr_arbiter4.sv | 24 ++
 rtl/dff_bank_ctrl.sv | 107 ++++++++++
 4 files changed

// File: rtl/dff_bank_pkg.sv
// Shared definitions for the DFF register-bank write controller.
package dff_bank_pkg;

    localparam int NREQ  = 4;
    localparam int GNT_W = 2;

    typedef enum logic {
        IDLE  = 1'b0,
        SWEEP = 1'b1
    } state_t;

endpackage

// File: rtl/dff_bank_ctrl_if.sv
// Requester/controller bus for dff_bank_ctrl; parity hook signals exist only
// when DFF_BANK_PARITY_EN is defined.
interface dff_bank_ctrl_if
    import dff_bank_pkg::*;
#(
    parameter int WIDTH = 8,
    parameter int DEPTH = 8
) ();
    localparam int AW = $clog2(DEPTH);

    logic [NREQ-1:0]       req;
    logic [NREQ*AW-1:0]    wr_addr;
    logic [NREQ*WIDTH-1:0] wr_data;
    logic [NREQ-1:0]       ack;
    logic [GNT_W-1:0]      gnt_id;
    logic                  sweep_req;
    logic                  busy;
    logic                  done;
    logic [AW-1:0]         rd_addr;
    logic [WIDTH-1:0]      rd_data;

`ifdef DFF_BANK_PARITY_EN
    logic                  inj_perr;
    logic                  rd_perr;

    modport master (
        output req, wr_addr, wr_data, sweep_req, rd_addr, inj_perr,
        input  ack, gnt_id, busy, done, rd_data, rd_perr
    );
    modport slave (
        input  req, wr_addr, wr_data, sweep_req, rd_addr, inj_perr,
        output ack, gnt_id, busy, done, rd_data, rd_perr
    );
`else
    modport master (
        output req, wr_addr, wr_data, sweep_req, rd_addr,
        input  ack, gnt_id, busy, done, rd_data
    );
    modport slave (
        input  req, wr_addr, wr_data, sweep_req, rd_addr,
        output ack, gnt_id, busy, done, rd_data
    );
`endif

endinterface

// File: rtl/rr_arbiter4.sv
// Combinational four-way round-robin pick: first eligible index at or after ptr.
module rr_arbiter4
    import dff_bank_pkg::*;
(
    input  logic [NREQ-1:0]  elig,
    input  logic [GNT_W-1:0] ptr,
    output logic             valid,
    output logic [GNT_W-1:0] win
);

    logic [GNT_W-1:0] idx;

    // Scan from the farthest offset back to ptr so the nearest eligible index wins.
    always_comb begin
        valid = |elig;
        win   = ptr;
        idx   = ptr;
        for (int off = NREQ - 1; off >= 0; off--) begin
            idx = ptr + GNT_W'(off);
            if (elig[idx]) win = idx;
        end
    end

endmodule

// File: rtl/dff_bank_ctrl.sv
// Round-robin write controller and clear sweeper for a DEPTH x WIDTH DFF bank.
// Optional per-entry parity with injection hook: define DFF_BANK_PARITY_EN.
module dff_bank_ctrl
    import dff_bank_pkg::*;
#(
    parameter int WIDTH = 8,
    parameter int DEPTH = 8
) (
    input  logic           clk,
    input  logic           clr,
    dff_bank_ctrl_if.slave bus
);

    localparam int AW = $clog2(DEPTH);

    state_t            state;
    logic [GNT_W-1:0]  ptr;
    logic [AW-1:0]     cnt;
    logic [NREQ-1:0]   ack_q;
    logic [GNT_W-1:0]  gnt_q;
    logic              busy_q;
    logic              done_q;
    logic [WIDTH-1:0]  bank [DEPTH];
`ifdef DFF_BANK_PARITY_EN
    logic [DEPTH-1:0]  par;
`endif

    logic [NREQ-1:0]   elig;
    logic              valid;
    logic [GNT_W-1:0]  win;
    logic [AW-1:0]     win_addr;
    logic [WIDTH-1:0]  win_data;

    // Masking by the registered ACK keeps a requester from being granted twice
    // while it is still lowering REQ.
    assign elig     = bus.req & ~ack_q;
    assign win_addr = bus.wr_addr[win*AW +: AW];
    assign win_data = bus.wr_data[win*WIDTH +: WIDTH];

    rr_arbiter4 u_arb (
        .elig  (elig),
        .ptr   (ptr),
        .valid (valid),
        .win   (win)
    );

    // NOTE: the bank is cleared by the async reset like any other register; it is
    // a DFF array, not a RAM macro, so resetting every entry is intended.
    always_ff @(posedge clk or posedge clr) begin
        if (clr) begin
            state  <= IDLE;
            ptr    <= '0;
            cnt    <= '0;
            ack_q  <= '0;
            gnt_q  <= '0;
            busy_q <= 1'b0;
            done_q <= 1'b0;
            for (int i = 0; i < DEPTH; i++) bank[i] <= '0;
`ifdef DFF_BANK_PARITY_EN
            par    <= '0;
`endif
        end else begin
            ack_q  <= '0;
            done_q <= 1'b0;
            case (state)
                IDLE: begin
                    if (bus.sweep_req) begin
                        state  <= SWEEP;
                        cnt    <= '0;
                        busy_q <= 1'b1;
                    end else if (valid) begin
                        bank[win_addr] <= win_data;
`ifdef DFF_BANK_PARITY_EN
                        par[win_addr]  <= (^win_data) ^ bus.inj_perr;
`endif
                        ack_q[win]     <= 1'b1;
                        gnt_q          <= win;
                        ptr            <= win + 2'd1;
                    end
                end
                SWEEP: begin
                    bank[cnt] <= '0;
`ifdef DFF_BANK_PARITY_EN
                    par[cnt]  <= 1'b0;
`endif
                    cnt       <= cnt + 1'b1;
                    if (cnt == AW'(DEPTH - 1)) begin
                        state  <= IDLE;
                        busy_q <= 1'b0;
                        done_q <= 1'b1;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign bus.ack     = ack_q;
    assign bus.gnt_id  = gnt_q;
    assign bus.busy    = busy_q;
    assign bus.done    = done_q;
    assign bus.rd_data = bank[bus.rd_addr];
`ifdef DFF_BANK_PARITY_EN
    assign bus.rd_perr = par[bus.rd_addr] ^ (^bank[bus.rd_addr]);
`endif

endmodule
